// File: rtl/if_id_pipe_reg.sv
// ----------------------------------------------------------------------------
// if_id_pipe_reg
//   IF/ID pipeline register for the MIPS pipeline. Carries the fetched
//   instruction, its PC and PC+PC_INC from fetch to decode behind a
//   valid/ready handshake, with backpressure, synchronous flush and
//   asynchronous active-low reset. Latency is one cycle and the stage
//   sustains one instruction per cycle.
//
//   Optional feature macro: IF_ID_SKID_EN
//     defined   : one-entry skid register behind the output register, so
//                 in_ready comes straight from a flop (in_ready = !skid_valid).
//     undefined : the output register is the only storage and
//                 in_ready = !out_valid || out_ready (combinational).
//
// Parameters
//   INSTR_W    instruction width
//   ADDR_W     PC width
//   PC_INC     increment added to in_pc to form out_pc_next
//   NOP_INSTR  value on out_instr while the stage is empty or flushed
//
// Ports
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous reset, active-low
//   in_valid     in   fetch presents a valid instruction
//   in_ready     out  stage can accept this cycle
//   in_instr     in   fetched instruction
//   in_pc        in   PC of the fetched instruction
//   flush        in   squash every held instruction (taken branch/jump)
//   out_valid    out  decode-side data valid
//   out_ready    in   decode accepts this cycle
//   out_instr    out  held instruction (NOP_INSTR when empty)
//   out_pc       out  held PC (keeps last value when empty)
//   out_pc_next  out  held PC + PC_INC, wrapping modulo 2^ADDR_W
// ----------------------------------------------------------------------------
module if_id_pipe_reg #(
    parameter int unsigned          INSTR_W   = 32,
    parameter int unsigned          ADDR_W    = 32,
    parameter int unsigned          PC_INC    = 4,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [ADDR_W-1:0]   in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [ADDR_W-1:0]   out_pc_next
);

    logic               out_valid_q,   out_valid_d;
    logic [INSTR_W-1:0] out_instr_q,   out_instr_d;
    logic [ADDR_W-1:0]  out_pc_q,      out_pc_d;
    logic [ADDR_W-1:0]  out_pc_next_q, out_pc_next_d;

    logic [ADDR_W-1:0]  in_pc_next;
    logic               accept;
    logic               out_free;

    // Truncation to ADDR_W bits gives the required wrap (no carry-out).
    assign in_pc_next = in_pc + ADDR_W'(PC_INC);

    // Output register may be overwritten at this edge: empty or being consumed.
    assign out_free = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef IF_ID_SKID_EN
    logic               skid_valid_q,   skid_valid_d;
    logic [INSTR_W-1:0] skid_instr_q,   skid_instr_d;
    logic [ADDR_W-1:0]  skid_pc_q,      skid_pc_d;
    logic [ADDR_W-1:0]  skid_pc_next_q, skid_pc_next_d;

    // Depends only on a flop, so no combinational path from out_ready.
    assign in_ready = !skid_valid_q;

    always_comb begin
        // NOTE: every signal gets a hold default first so no branch can infer a latch.
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_pc_d       = out_pc_q;
        out_pc_next_d  = out_pc_next_q;
        skid_valid_d   = skid_valid_q;
        skid_instr_d   = skid_instr_q;
        skid_pc_d      = skid_pc_q;
        skid_pc_next_d = skid_pc_next_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            out_instr_d  = NOP_INSTR;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // Older skid entry goes first; in_ready was low so nothing new arrives.
                out_valid_d   = 1'b1;
                out_instr_d   = skid_instr_q;
                out_pc_d      = skid_pc_q;
                out_pc_next_d = skid_pc_next_q;
                skid_valid_d  = 1'b0;
            end else if (accept) begin
                out_valid_d   = 1'b1;
                out_instr_d   = in_instr;
                out_pc_d      = in_pc;
                out_pc_next_d = in_pc_next;
            end else begin
                out_valid_d = 1'b0;
                out_instr_d = NOP_INSTR;
            end
        end else if (accept) begin
            // Output is stalled: park the new instruction in the skid register.
            skid_valid_d   = 1'b1;
            skid_instr_d   = in_instr;
            skid_pc_d      = in_pc;
            skid_pc_next_d = in_pc_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            skid_valid_q <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
        end
    end

    // NOTE: skid payload has no reset; skid_valid_q alone decides whether it is used.
    always_ff @(posedge clock) begin
        skid_instr_q   <= skid_instr_d;
        skid_pc_q      <= skid_pc_d;
        skid_pc_next_q <= skid_pc_next_d;
    end
`else
    assign in_ready = out_free;

    always_comb begin
        // NOTE: every signal gets a hold default first so no branch can infer a latch.
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        out_pc_next_d = out_pc_next_q;

        if (flush) begin
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            out_instr_d   = in_instr;
            out_pc_d      = in_pc;
            out_pc_next_d = in_pc_next;
        end else if (out_free) begin
            // Consumed (or already empty) with nothing new: show NOP, keep PCs.
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
        end
    end
`endif

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q   <= 1'b0;
            out_instr_q   <= NOP_INSTR;
            out_pc_q      <= '0;
            out_pc_next_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            out_pc_next_q <= out_pc_next_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign out_pc_next = out_pc_next_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// ----------------------------------------------------------------------------
// tb_if_id_pipe_reg
//   Self-checking bench for if_id_pipe_reg. A queue model of the stage
//   (capacity 1 without skid, 2 with IF_ID_SKID_EN) predicts every output;
//   directed sequences pin reset, streaming, backpressure, flush and PC wrap
//   with literal values, and a second instance covers narrow parameters.
// ----------------------------------------------------------------------------
module tb_if_id_pipe_reg;

    localparam logic [31:0] NOP = 32'h0;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_next;

    // Narrow instance: INSTR_W=16, ADDR_W=12, PC_INC=2.
    logic        p_in_valid = 1'b0;
    logic        p_in_ready;
    logic [15:0] p_in_instr = '0;
    logic [11:0] p_in_pc = '0;
    logic        p_out_valid;
    logic [15:0] p_out_instr;
    logic [11:0] p_out_pc;
    logic [11:0] p_out_pc_next;

    int n_tests = 0;
    int n_fail  = 0;

    if_id_pipe_reg dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pc_next (out_pc_next)
    );

    if_id_pipe_reg #(
        .INSTR_W   (16),
        .ADDR_W    (12),
        .PC_INC    (2),
        .NOP_INSTR (16'h0)
    ) dut_p (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (p_in_valid),
        .in_ready    (p_in_ready),
        .in_instr    (p_in_instr),
        .in_pc       (p_in_pc),
        .flush       (1'b0),
        .out_valid   (p_out_valid),
        .out_ready   (1'b1),
        .out_instr   (p_out_instr),
        .out_pc      (p_out_pc),
        .out_pc_next (p_out_pc_next)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the stage is a FIFO of held entries; the head is
    // what out_* shows. PCs on the output keep the last head's values.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_last_pc      = '0;
    logic [31:0] m_last_pc_next = '0;

    function automatic bit model_in_ready();
`ifdef IF_ID_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || out_ready;
`endif
    endfunction

    initial begin
        bit acc;
        bit cons;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                m_last_pc      = '0;
                m_last_pc_next = '0;
            end else begin
                acc  = in_valid && model_in_ready();
                cons = (mq.size() > 0) && out_ready;
                if (flush) begin
                    mq.delete();
                end else begin
                    if (cons) void'(mq.pop_front());
                    if (acc) mq.push_back('{instr: in_instr, pc: in_pc});
                end
                if (mq.size() > 0) begin
                    m_last_pc      = mq[0].pc;
                    m_last_pc_next = mq[0].pc + 32'd4;
                end
            end
        end
    end

    // Compare process: every cycle, between edges.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            check("cmp_out_valid", out_valid, mq.size() > 0);
            check("cmp_in_ready", in_ready, model_in_ready());
            check("cmp_out_instr", out_instr, (mq.size() > 0) ? mq[0].instr : NOP);
            check("cmp_out_pc", out_pc, m_last_pc);
            check("cmp_out_pc_next", out_pc_next, m_last_pc_next);
        end
    end

    // Inputs change 2 units after the falling edge, after the compare.
    task automatic apply(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic fl, input logic ordy);
        @(negedge clock);
        #2;
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [31:0] instr,
                              input logic [31:0] pc, input logic [31:0] pcn);
        check({name, "_valid"}, out_valid, v);
        check({name, "_instr"}, out_instr, instr);
        check({name, "_pc"}, out_pc, pc);
        check({name, "_pc_next"}, out_pc_next, pcn);
    endtask

    logic [31:0] s_pc[3];
    logic [31:0] s_instr[3];

    initial begin
        s_pc[0] = 32'h100;  s_instr[0] = 32'h20080005;
        s_pc[1] = 32'h104;  s_instr[1] = 32'h20090003;
        s_pc[2] = 32'h108;  s_instr[2] = 32'h01095020;

        // Reset state before any edge is released.
        #3;
        expect_out("reset", 1'b0, NOP, 32'h0, 32'h0);
        check("reset_in_ready", in_ready, 1'b1);
        @(negedge clock);
        #3;
        reset_n = 1'b1;

        // Stream of three back-to-back instructions.
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, s_instr[i], s_pc[i], 1'b0, 1'b1);
            after_edge();
            expect_out("stream", 1'b1, s_instr[i], s_pc[i], s_pc[i] + 32'h4);
            if (i == 0) check("model_pc_next", m_last_pc_next, 32'h104);
        end
        apply(1'b0, '0, '0, 1'b0, 1'b1);
        after_edge();
        expect_out("stream_drain", 1'b0, NOP, 32'h108, 32'h10C);

        // Backpressure: A then B while decode stalls for 3 cycles.
        apply(1'b1, 32'hAAAA0001, 32'h200, 1'b0, 1'b0);
        after_edge();
        expect_out("bp_a", 1'b1, 32'hAAAA0001, 32'h200, 32'h204);
`ifdef IF_ID_SKID_EN
        check("bp_ready_after_a", in_ready, 1'b1);
`else
        check("bp_ready_after_a", in_ready, 1'b0);
`endif
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 32'hBBBB0002, 32'h204, 1'b0, 1'b0);
            after_edge();
            expect_out("bp_hold", 1'b1, 32'hAAAA0001, 32'h200, 32'h204);
            check("bp_ready_hold", in_ready, 1'b0);
        end
        apply(1'b1, 32'hBBBB0002, 32'h204, 1'b0, 1'b1);
        after_edge();
        expect_out("bp_b", 1'b1, 32'hBBBB0002, 32'h204, 32'h208);
        apply(1'b0, '0, '0, 1'b0, 1'b1);
        after_edge();
        check("bp_drain_valid", out_valid, 1'b0);

        // Flush with a full stage and an offered instruction.
        apply(1'b1, 32'hCCCC0003, 32'h300, 1'b0, 1'b0);
        apply(1'b1, 32'hDDDD0004, 32'h304, 1'b0, 1'b0);
        apply(1'b1, 32'hEEEE0005, 32'h308, 1'b1, 1'b0);
        after_edge();
        expect_out("flush", 1'b0, NOP, 32'h300, 32'h304);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, '0, '0, 1'b0, 1'b1);
            after_edge();
            expect_out("flush_after", 1'b0, NOP, 32'h300, 32'h304);
        end

        // PC wrap.
        apply(1'b1, 32'h1234ABCD, 32'hFFFFFFFC, 1'b0, 1'b1);
        after_edge();
        expect_out("wrap", 1'b1, 32'h1234ABCD, 32'hFFFFFFFC, 32'h00000000);

        // Asynchronous reset mid-stream, no clock edge in between.
        #1;
        reset_n = 1'b0;
        #1;
        expect_out("async_reset", 1'b0, NOP, 32'h0, 32'h0);
        apply(1'b0, '0, '0, 1'b0, 1'b1);
        @(negedge clock);
        #3;
        reset_n = 1'b1;

        // Narrow parameter instance wrap.
        @(negedge clock);
        #2;
        p_in_valid = 1'b1;
        p_in_instr = 16'hBEEF;
        p_in_pc    = 12'hFFE;
        after_edge();
        check("param_valid", p_out_valid, 1'b1);
        check("param_instr", p_out_instr, 16'hBEEF);
        check("param_pc", p_out_pc, 12'hFFE);
        check("param_pc_next", p_out_pc_next, 12'h000);
        @(negedge clock);
        #2;
        p_in_valid = 1'b0;
        after_edge();
        check("param_drain_instr", p_out_instr, 16'h0);
        check("param_drain_pc_next", p_out_pc_next, 12'h000);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 3) != 0,
                  $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0);
        end
        apply(1'b0, '0, '0, 1'b0, 1'b1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        #3;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
